// File: rtl/bridge_pkg.sv
// Shared types and constants for the sram-like to AXI3 bridge.
package bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_WR_ADDR,
        ST_WR_RESP,
        ST_DONE
    } state_t;

    typedef enum logic {
        OWN_INST,
        OWN_DATA
    } owner_t;

    localparam logic [1:0] SIZE_BYTE      = 2'd0;
    localparam logic [1:0] SIZE_HALF      = 2'd1;
    localparam logic [1:0] SIZE_WORD      = 2'd2;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

endpackage

// File: rtl/sramlike_wstrb_gen.sv
// Byte-lane write strobe from sram-like size and the low address bits.
module sramlike_wstrb_gen
    import bridge_pkg::*;
(
    input  logic [1:0] i_size,
    input  logic [1:0] i_addr_lo,
    output logic [3:0] o_wstrb
);

    // Byte selects one lane, half selects the upper or lower pair, word/3 select all.
    always_comb begin
        o_wstrb = 4'b1111;
        case (i_size)
            SIZE_BYTE: o_wstrb = 4'b0001 << i_addr_lo;
            SIZE_HALF: o_wstrb = i_addr_lo[1] ? 4'b1100 : 4'b0011;
            default:   o_wstrb = 4'b1111;
        endcase
    end

endmodule

// File: rtl/sramlike_axi_bridge.sv
// Arbitrates the inst and data sram-like ports onto one AXI3 master port.
// One outstanding single-beat transaction; the data port has fixed priority.
module sramlike_axi_bridge
    import bridge_pkg::*;
#(
    parameter logic [3:0] ID_INST = 4'd0,
    parameter logic [3:0] ID_DATA = 4'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic [31:0] inst_rdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    state_t      r_state;
    state_t      w_next;
    owner_t      r_owner;
    logic        r_wr;
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_aw_pend;
    logic        r_w_pend;

    logic        w_idle;
    logic        w_acc_data;
    logic        w_acc_inst;
    logic        w_acc_wr;
    logic [3:0]  w_axi_id;
    logic        w_unused;

    // Acceptance is combinational in IDLE and suppressed while reset is high,
    // so a request is never acknowledged in a cycle that cannot latch it.
    assign w_idle     = (r_state == ST_IDLE);
    assign w_acc_data = w_idle & data_req & ~rst;
    assign w_acc_inst = w_idle & inst_req & ~data_req & ~rst;
    assign w_acc_wr   = (w_acc_data & data_wr) | (w_acc_inst & inst_wr);

    assign data_addr_ok = w_acc_data;
    assign inst_addr_ok = w_acc_inst;

    assign w_axi_id = (r_owner == OWN_DATA) ? ID_DATA : ID_INST;

    assign arid    = w_axi_id;
    assign araddr  = r_addr;
    assign arlen   = '0;
    assign arsize  = {1'b0, r_size};
    assign arburst = AXI_BURST_INCR;
    assign arlock  = '0;
    assign arcache = '0;
    assign arprot  = '0;

    assign awid    = w_axi_id;
    assign awaddr  = r_addr;
    assign awlen   = '0;
    assign awsize  = {1'b0, r_size};
    assign awburst = AXI_BURST_INCR;
    assign awlock  = '0;
    assign awcache = '0;
    assign awprot  = '0;

    assign wid   = w_axi_id;
    assign wdata = r_wdata;
    assign wlast = 1'b1;

    assign inst_rdata = r_rdata;
    assign data_rdata = r_rdata;

    // Response IDs, resp codes and rlast carry nothing for single-beat bursts.
    assign w_unused = ^{rid, rresp, rlast, bid, bresp};

    sramlike_wstrb_gen u_wstrb (
        .i_size    (r_size),
        .i_addr_lo (r_addr[1:0]),
        .o_wstrb   (wstrb)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // Next-state and channel handshake outputs.
    always_comb begin
        w_next       = r_state;
        arvalid      = 1'b0;
        rready       = 1'b0;
        awvalid      = 1'b0;
        wvalid       = 1'b0;
        bready       = 1'b0;
        data_data_ok = 1'b0;
        inst_data_ok = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_acc_data || w_acc_inst) w_next = w_acc_wr ? ST_WR_ADDR : ST_RD_ADDR;
            end
            ST_RD_ADDR: begin
                arvalid = 1'b1;
                if (arready) w_next = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                rready = 1'b1;
                if (rvalid) w_next = ST_DONE;
            end
            ST_WR_ADDR: begin
                awvalid = r_aw_pend;
                wvalid  = r_w_pend;
                // Leave once neither channel still owes a handshake.
                if ((~r_aw_pend | awready) & (~r_w_pend | wready)) w_next = ST_WR_RESP;
            end
            ST_WR_RESP: begin
                bready = 1'b1;
                if (bvalid) w_next = ST_DONE;
            end
            ST_DONE: begin
                data_data_ok = (r_owner == OWN_DATA);
                inst_data_ok = (r_owner == OWN_INST);
                w_next       = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Latch the winning request at acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner <= OWN_INST;
            r_wr    <= 1'b0;
            r_size  <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_acc_data) begin
            r_owner <= OWN_DATA;
            r_wr    <= data_wr;
            r_size  <= data_size;
            r_addr  <= data_addr;
            r_wdata <= data_wdata;
        end else if (w_acc_inst) begin
            r_owner <= OWN_INST;
            r_wr    <= inst_wr;
            r_size  <= inst_size;
            r_addr  <= inst_addr;
            r_wdata <= inst_wdata;
        end
    end

    // Track the AW and W handshakes independently during a write.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_aw_pend <= 1'b0;
            r_w_pend  <= 1'b0;
        end else if (w_acc_wr) begin
            r_aw_pend <= 1'b1;
            r_w_pend  <= 1'b1;
        end else if (r_state == ST_WR_ADDR) begin
            if (awready) r_aw_pend <= 1'b0;
            if (wready)  r_w_pend  <= 1'b0;
        end
    end

    // Capture read data on the R handshake.
    always_ff @(posedge clk) begin
        if (rst)                                r_rdata <= '0;
        else if (r_state == ST_RD_DATA && rvalid) r_rdata <= rdata;
    end

endmodule

// File: tb/tb_sramlike_axi_bridge.sv
// Self-checking bench: table-driven strobe vectors, directed corner sequences
// and randomized traffic against a transaction-level memory model.
module tb_sramlike_axi_bridge;

    localparam logic [3:0] ID_INST = 4'd0;
    localparam logic [3:0] ID_DATA = 4'd1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_req = 0, inst_wr = 0;
    logic [1:0]  inst_size = 0;
    logic [31:0] inst_addr = 0, inst_wdata = 0;
    logic [31:0] inst_rdata;
    logic        inst_addr_ok, inst_data_ok;
    logic        data_req = 0, data_wr = 0;
    logic [1:0]  data_size = 0;
    logic [31:0] data_addr = 0, data_wdata = 0;
    logic [31:0] data_rdata;
    logic        data_addr_ok, data_data_ok;
    logic [3:0]  arid, awid, wid, arcache, awcache;
    logic [31:0] araddr, awaddr, wdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize, arprot, awprot;
    logic [1:0]  arburst, awburst, arlock, awlock;
    logic        arvalid, rready, awvalid, wvalid, wlast, bready;
    logic [3:0]  wstrb;
    logic        arready = 0, rvalid = 0, rlast = 0, awready = 0, wready = 0, bvalid = 0;
    logic [3:0]  rid = 0, bid = 0;
    logic [31:0] rdata = 0;
    logic [1:0]  rresp = 0, bresp = 0;

    sramlike_axi_bridge #(.ID_INST(4'd0), .ID_DATA(4'd1)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_data;
        bit          wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } req_t;

    typedef struct {
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  exp_strb;
    } wvec_t;

    int checks = 0;
    int errors = 0;

    req_t inst_q[$];
    req_t data_q[$];
    req_t cur;
    bit   busy, done_pend, ar_done, r_done, aw_done, w_done, b_done, b_started;
    bit   rst_next = 1'b1;
    bit   inst_en = 1'b1, data_en = 1'b1, rand_dly = 1'b0;

    logic [31:0] ref_mem [logic [29:0]];
    logic [31:0] slv_mem [logic [29:0]];

    int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
    bit r_pend, b_pend;
    logic [31:0] r_val;
    int k_ar, k_r, k_aw, k_w, k_b;

    int cyc = 0;
    int n_arv, n_awv, n_wv, n_aok, n_dok_data;
    int acc_cyc_data, acc_cyc_inst, dok_cyc_data, dok_cyc_inst, bhs_cyc;
    logic [3:0]  last_wstrb;
    logic [31:0] last_data_rdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [29:0] wa);
        return {wa, 2'b00} ^ 32'hA5A5_5A5A;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [29:0] wa);
        if (ref_mem.exists(wa)) return ref_mem[wa];
        return init_word(wa);
    endfunction

    function automatic logic [31:0] slv_rd(input logic [29:0] wa);
        if (slv_mem.exists(wa)) return slv_mem[wa];
        return init_word(wa);
    endfunction

    function automatic logic [3:0] model_strb(input logic [1:0] size, input logic [31:0] addr);
        int lane = int'(addr[1:0]);
        if (size == 2'd0) return 4'(1 << lane);
        if (size == 2'd1) return 4'(3 << (lane & 2));
        return 4'hF;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] strb);
        logic [31:0] res = old;
        for (int b = 0; b < 4; b++) if (strb[b]) res[8*b +: 8] = nw[8*b +: 8];
        return res;
    endfunction

    task automatic push(input bit is_data, input bit wr, input logic [1:0] size,
                        input logic [31:0] addr, input logic [31:0] wd);
        req_t r;
        r.is_data = is_data; r.wr = wr; r.size = size; r.addr = addr; r.wdata = wd; r.exp_rdata = '0;
        if (is_data) data_q.push_back(r); else inst_q.push_back(r);
    endtask

    task automatic accept(input bit is_data);
        if (is_data) begin cur = data_q.pop_front(); acc_cyc_data = cyc; end
        else         begin cur = inst_q.pop_front(); acc_cyc_inst = cyc; end
        cur.exp_rdata = ref_rd(cur.addr[31:2]);
        if (cur.wr) ref_mem[cur.addr[31:2]] = merge(ref_rd(cur.addr[31:2]), cur.wdata, model_strb(cur.size, cur.addr));
        busy = 1; done_pend = 0;
        ar_done = 0; r_done = 0; aw_done = 0; w_done = 0; b_done = 0; b_started = 0;
        if (rand_dly) begin
            k_ar = $urandom_range(0, 3); k_r = $urandom_range(0, 3);
            k_aw = $urandom_range(0, 3); k_w = $urandom_range(0, 3); k_b = $urandom_range(0, 3);
        end
        ar_cnt = k_ar; aw_cnt = k_aw; w_cnt = k_w;
    endtask

    task automatic monitor();
        bit busy0 = busy;
        bit e_arv, e_rr, e_awv, e_wv, e_br;
        logic [3:0] e_id;
        if (rst) begin
            chk("rst_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 0);
            return;
        end
        e_id  = cur.is_data ? ID_DATA : ID_INST;
        e_arv = busy0 && !cur.wr && !ar_done;
        e_rr  = busy0 && !cur.wr && ar_done && !r_done;
        e_awv = busy0 && cur.wr && !aw_done;
        e_wv  = busy0 && cur.wr && !w_done;
        e_br  = busy0 && cur.wr && aw_done && w_done && !b_done;
        chk("arvalid", arvalid, e_arv);
        chk("rready", rready, e_rr);
        chk("awvalid", awvalid, e_awv);
        chk("wvalid", wvalid, e_wv);
        chk("bready", bready, e_br);
        chk("axi_const", {arlock, arcache, arprot, awlock, awcache, awprot}, 0);
        chk("data_data_ok", data_data_ok, done_pend && cur.is_data);
        chk("inst_data_ok", inst_data_ok, done_pend && !cur.is_data);
        if (busy0) chk("addr_ok_busy", {30'd0, inst_addr_ok, data_addr_ok}, 0);
        else begin
            chk("data_addr_ok", data_addr_ok, data_req);
            chk("inst_addr_ok", inst_addr_ok, inst_req && !data_req);
        end
        if (e_arv) begin
            chk("araddr", araddr, cur.addr); chk("arid", arid, e_id);
            chk("arsize", arsize, cur.size); chk("arlen", arlen, 0); chk("arburst", arburst, 1);
        end
        if (e_awv) begin
            chk("awaddr", awaddr, cur.addr); chk("awid", awid, e_id);
            chk("awsize", awsize, cur.size); chk("awlen", awlen, 0); chk("awburst", awburst, 1);
        end
        if (e_wv) begin
            chk("wdata", wdata, cur.wdata); chk("wstrb", wstrb, model_strb(cur.size, cur.addr));
            chk("wid", wid, e_id); chk("wlast", wlast, 1);
        end
        if (done_pend) begin
            if (cur.is_data) begin
                dok_cyc_data = cyc; n_dok_data++; last_data_rdata = data_rdata;
                if (!cur.wr) chk("data_rdata", data_rdata, cur.exp_rdata);
            end else begin
                dok_cyc_inst = cyc;
                if (!cur.wr) chk("inst_rdata", inst_rdata, cur.exp_rdata);
            end
            busy = 0; done_pend = 0;
        end
        n_arv += int'(arvalid); n_awv += int'(awvalid); n_wv += int'(wvalid);
        n_aok += int'(data_addr_ok) + int'(inst_addr_ok);
        if (busy0) begin
            if (arvalid && arready) begin
                ar_done = 1; r_pend = 1; r_cnt = k_r; r_val = slv_rd(araddr[31:2]);
            end
            if (rvalid && rready) begin r_done = 1; r_pend = 0; done_pend = 1; end
            if (awvalid && awready) aw_done = 1;
            if (wvalid && wready) begin
                w_done = 1; last_wstrb = wstrb;
                slv_mem[awaddr[31:2]] = merge(slv_rd(awaddr[31:2]), wdata, wstrb);
            end
            if (aw_done && w_done && !b_started) begin b_started = 1; b_pend = 1; b_cnt = k_b; end
            if (bvalid && bready) begin b_done = 1; b_pend = 0; done_pend = 1; bhs_cyc = cyc; end
        end else if (data_req && data_addr_ok) accept(1'b1);
        else if (inst_req && inst_addr_ok) accept(1'b0);
    endtask

    // One clock: drive master and slave after the edge, then sample and update the model.
    task automatic cycle();
        @(posedge clk);
        #1;
        cyc++;
        rst = rst_next;
        if (data_en && data_q.size() > 0) begin
            data_req = 1; data_wr = data_q[0].wr; data_size = data_q[0].size;
            data_addr = data_q[0].addr; data_wdata = data_q[0].wdata;
        end else begin
            data_req = 0; data_wr = 1'($urandom); data_addr = $urandom; data_wdata = $urandom;
        end
        if (inst_en && inst_q.size() > 0) begin
            inst_req = 1; inst_wr = inst_q[0].wr; inst_size = inst_q[0].size;
            inst_addr = inst_q[0].addr; inst_wdata = inst_q[0].wdata;
        end else begin
            inst_req = 0; inst_wr = 1'($urandom); inst_addr = $urandom; inst_wdata = $urandom;
        end
        rid = 4'($urandom); rresp = 2'($urandom); rlast = 1'($urandom);
        bid = 4'($urandom); bresp = 2'($urandom);
        if (rst) begin
            busy = 0; done_pend = 0; r_pend = 0; b_pend = 0; b_started = 0;
            arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
        end else begin
            if (arvalid) begin
                if (ar_cnt == 0) arready = 1; else begin arready = 0; ar_cnt--; end
            end else arready = 1'($urandom);
            if (awvalid) begin
                if (aw_cnt == 0) awready = 1; else begin awready = 0; aw_cnt--; end
            end else awready = 1'($urandom);
            if (wvalid) begin
                if (w_cnt == 0) wready = 1; else begin wready = 0; w_cnt--; end
            end else wready = 1'($urandom);
            if (r_pend && r_cnt == 0) begin rvalid = 1; rdata = r_val; end
            else begin rvalid = 0; rdata = $urandom; if (r_pend) r_cnt--; end
            if (b_pend && b_cnt == 0) bvalid = 1;
            else begin bvalid = 0; if (b_pend) b_cnt--; end
        end
        #1;
        monitor();
    endtask

    task automatic wait_idle(input int budget);
        bit pending;
        for (int i = 0; i < budget; i++) begin
            if (!busy && data_q.size() == 0 && inst_q.size() == 0) break;
            cycle();
        end
        pending = busy || data_q.size() != 0 || inst_q.size() != 0;
        chk("idle_timeout", {31'd0, pending}, 0);
    endtask

    wvec_t tbl [8];

    initial begin
        int n_push;
        bit seen;
        int dok_before;

        tbl[0] = '{2'd0, 32'h8000_0003, 32'hAB00_0000, 4'b1000};
        tbl[1] = '{2'd0, 32'h8000_0000, 32'h0000_00CD, 4'b0001};
        tbl[2] = '{2'd0, 32'h8000_0001, 32'h0000_EF00, 4'b0010};
        tbl[3] = '{2'd0, 32'h8000_0002, 32'h0012_0000, 4'b0100};
        tbl[4] = '{2'd1, 32'h8000_0006, 32'h3344_0000, 4'b1100};
        tbl[5] = '{2'd1, 32'h8000_0004, 32'h0000_5566, 4'b0011};
        tbl[6] = '{2'd2, 32'h8000_0008, 32'hDEAD_BEEF, 4'b1111};
        tbl[7] = '{2'd3, 32'h8000_000C, 32'hCAFE_F00D, 4'b1111};

        // Reset state, with a request already waiting at the data port.
        push(1'b1, 1'b0, 2'd2, 32'h0000_0040, 32'h0);
        rst_next = 1;
        for (int i = 0; i < 3; i++) cycle();
        chk("rst_valids", {25'd0, arvalid, rready, awvalid, wvalid, bready, data_data_ok, inst_data_ok}, 0);
        chk("rst_rdata", data_rdata, 0);
        rst_next = 0;
        wait_idle(50);

        // Word read with immediate slave and minimum latency.
        ref_mem[30'h2FF0_0004] = 32'h1234_5678;
        slv_mem[30'h2FF0_0004] = 32'h1234_5678;
        push(1'b1, 1'b0, 2'd2, 32'hBFC0_0010, 32'h0);
        wait_idle(50);
        chk("t1_latency", dok_cyc_data - acc_cyc_data, 3);
        chk("t1_rdata", last_data_rdata, 32'h1234_5678);

        // Strobe table: data-port stores, immediate slave.
        foreach (tbl[i]) begin
            push(1'b1, 1'b1, tbl[i].size, tbl[i].addr, tbl[i].wdata);
            wait_idle(50);
            chk("tbl_wstrb", last_wstrb, tbl[i].exp_strb);
            chk("tbl_latency", dok_cyc_data - acc_cyc_data, 3);
        end
        for (int i = 0; i < 4; i++) push(1'b1, 1'b0, 2'd2, 32'h8000_0000 + 32'(4 * i), 32'h0);
        wait_idle(100);

        // Simultaneous requests: data first, inst the cycle after data_ok.
        data_en = 0; inst_en = 0;
        push(1'b1, 1'b0, 2'd2, 32'h0000_0100, 32'h0);
        push(1'b0, 1'b0, 2'd2, 32'h0000_0200, 32'h0);
        data_en = 1; inst_en = 1;
        wait_idle(50);
        chk("t2_inst_after_dok", acc_cyc_inst - dok_cyc_data, 1);
        chk("t2_data_first", {31'd0, acc_cyc_data < acc_cyc_inst}, 1);

        // Byte store, AW ready on its third cycle, W immediate.
        k_aw = 2; n_awv = 0; n_wv = 0;
        push(1'b1, 1'b1, 2'd0, 32'h8000_0003, 32'hAB00_0000);
        wait_idle(50);
        k_aw = 0;
        chk("t3_wstrb", last_wstrb, 4'b1000);
        chk("t3_wvalid_cycles", n_wv, 1);
        chk("t3_awvalid_cycles", n_awv, 3);
        chk("t3_dok_after_b", dok_cyc_data - bhs_cyc, 1);

        // AR backpressure for 5 cycles with a second request waiting.
        k_ar = 5; n_arv = 0; n_aok = 0;
        push(1'b1, 1'b0, 2'd2, 32'h8000_0004, 32'h0);
        push(1'b1, 1'b0, 2'd1, 32'h8000_0006, 32'h0);
        wait_idle(80);
        k_ar = 0;
        chk("t5_arvalid_cycles", n_arv, 12);
        chk("t5_addr_ok_count", n_aok, 2);

        // Reset while waiting for read data.
        k_r = 10;
        push(1'b1, 1'b0, 2'd2, 32'h0000_0300, 32'h0);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin cycle(); seen = rready; end
        chk("t6_reached_rd_data", {31'd0, seen}, 1);
        k_r = 0;
        dok_before = n_dok_data;
        rst_next = 1; cycle(); rst_next = 0;
        cycle();
        chk("t6_rready_after_rst", rready, 0);
        for (int i = 0; i < 5; i++) cycle();
        chk("t6_no_dok", n_dok_data - dok_before, 0);
        push(1'b1, 1'b0, 2'd2, 32'h0000_0300, 32'h0);
        wait_idle(50);
        chk("t6_fresh_read", n_dok_data - dok_before, 1);

        // Randomized traffic on both ports with random slave delays.
        rand_dly = 1; n_push = 0;
        for (int i = 0; i < 600; i++) begin
            if (n_push < 60 && $urandom_range(0, 3) == 0) begin
                logic [1:0]  sz = 2'($urandom_range(0, 3));
                logic [31:0] a  = 32'h1000_0000 | (32'($urandom_range(0, 7)) << 2);
                if (sz == 2'd0) a[1:0] = 2'($urandom);
                else if (sz == 2'd1) a[1] = 1'($urandom);
                push(($urandom_range(0, 2) != 0), 1'($urandom), sz, a, $urandom);
                n_push++;
            end
            cycle();
        end
        wait_idle(3000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
